mem_backdoor_burst_ctrl: RTL

Synthesizable backdoor burst engine for the Ethernet testbench memory model. It accepts a burst command (address, length, direction) over a valid/ready handshake. Write bursts stream data beats onto the memory backdoor port; read bursts collect returned data from it. It replaces fixed 10-word backdoor writes with parametrised-length read and write bursts that the transactor drives from the HVL side.

---
 rtl/mem_backdoor_burst_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_backdoor_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_backdoor_burst_ctrl
//
// Backdoor burst engine for the Ethernet testbench memory model. A burst
// command (start address, beat count, direction) is taken over a valid/ready
// handshake. Write bursts stream data beats onto the memory backdoor port.
// Read bursts issue back-to-back reads and return the data on the rdata port.
//
// Optional feature macro: MEM_BCKDR_RD_EN
//   defined   : read path present (RD/DRAIN states, read-valid shift register,
//               rdata* outputs).
//   undefined : read path omitted; rdata*, mem_read tied 0; a read command
//               completes as a rejected command (done=err=1).
//
// Handshake rule (cmd_* and wdata_*): a transfer happens on a rising edge
// where both valid and ready are 1. Ready is a registered output and never
// depends combinationally on valid. rdata_valid has no backpressure.
//
// Ports
//   wb_clk, wb_rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write, cmd_addr, cmd_len direction (1=write), start word addr, beats
//   wdata_valid/wdata_ready      write beat handshake, wdata payload
//   rdata_valid, rdata           read beat, rdata_last on final beat
//   done, err                    one-cycle completion pulse, err = rejected
//   mem_addr, mem_write,         backdoor memory port
//   mem_read, mem_wdata, mem_rdata
//   dbg_state                    current FSM state (debug observation)
// ---------------------------------------------------------------------------
module mem_backdoor_burst_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MAX_LEN = 16,
  parameter int RD_LAT  = 1,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  output logic [DW-1:0] rdata,
  output logic          rdata_last,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_cmd_ready;
  logic          r_wdata_ready;
  logic          r_done;
  logic          r_err;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_write;
  logic [DW-1:0] r_mem_wdata;

  logic          w_accept;
  logic          w_reject;
  logic          w_wbeat;
  logic          w_rbeat;
  logic [LW-1:0] w_len_m1;

  assign w_len_m1 = r_len - LW'(1);

`ifdef MEM_BCKDR_RD_EN
  logic              r_mem_read;
  logic [RD_LAT-1:0] r_vsr;
  logic [LW-1:0]     r_rcnt;
  logic              r_rdata_valid;
  logic              r_rdata_last;
  logic [DW-1:0]     r_rdata;
`endif

  // Next-state logic. Every registered output is derived from the next state
  // so that it is valid in the first cycle of that state.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_wbeat     = 1'b0;
    w_rbeat     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept = 1'b1;
          if ((cmd_len == '0) || (cmd_len > MAX_LEN_W)) begin
            w_reject = 1'b1;
          end
`ifndef MEM_BCKDR_RD_EN
          // No read path in this build: a read completes as a rejection.
          if (!cmd_write) begin
            w_reject = 1'b1;
          end
`endif
          if (w_reject) begin
            w_state_nxt = FIN;
          end else if (cmd_write) begin
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      WR: begin
        if (wdata_valid && r_wdata_ready) begin
          w_wbeat = 1'b1;
          if (r_cnt == w_len_m1) begin
            w_state_nxt = FIN;
          end
        end
      end
`ifdef MEM_BCKDR_RD_EN
      RD: begin
        // One read per cycle, no gaps.
        w_rbeat = 1'b1;
        if (r_cnt == w_len_m1) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Pipeline empty and final beat on the output this cycle.
        if ((r_vsr == '0) && r_rdata_last) begin
          w_state_nxt = FIN;
        end
      end
`endif
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_base        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      r_mem_write   <= 1'b0;
      r_mem_wdata   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= (w_state_nxt == IDLE);
      r_wdata_ready <= (w_state_nxt == WR);
      r_done        <= (w_state_nxt == FIN);
      r_err         <= w_accept && w_reject;
      r_mem_write   <= w_wbeat;
      if (w_accept) begin
        r_base <= cmd_addr;
        r_len  <= cmd_len;
        r_cnt  <= '0;
      end else if (w_wbeat || w_rbeat) begin
        r_cnt <= r_cnt + LW'(1);
      end
      // Address wraps modulo 2^AW through the natural adder width.
      if (w_wbeat || w_rbeat) begin
        r_mem_addr <= r_base + AW'(r_cnt);
      end
      if (w_wbeat) begin
        r_mem_wdata <= wdata;
      end
    end
  end

`ifdef MEM_BCKDR_RD_EN
  // Read return path: mem_read is delayed through an RD_LAT-deep valid shift
  // register whose top bit lines up with valid mem_rdata.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_mem_read    <= 1'b0;
      r_vsr         <= '0;
      r_rcnt        <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_mem_read <= w_rbeat;
      r_vsr[0]   <= r_mem_read;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vsr[k] <= r_vsr[k-1];
      end
      r_rdata_valid <= r_vsr[RD_LAT-1];
      r_rdata_last  <= r_vsr[RD_LAT-1] && (r_rcnt == w_len_m1);
      if (r_vsr[RD_LAT-1]) begin
        r_rdata <= mem_rdata;
        r_rcnt  <= r_rcnt + LW'(1);
      end
      if (w_accept) begin
        r_rcnt <= '0;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rdata_last  = r_rdata_last;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{mem_rdata, (RD_LAT < 1)};

  assign mem_read    = 1'b0;
  assign rdata_valid = 1'b0;
  assign rdata       = '0;
  assign rdata_last  = 1'b0;
`endif

  assign cmd_ready   = r_cmd_ready;
  assign wdata_ready = r_wdata_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign mem_addr    = r_mem_addr;
  assign mem_write   = r_mem_write;
  assign mem_wdata   = r_mem_wdata;
  assign dbg_state   = r_state;

endmodule
